// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
//   Arbitrates four pixel-drawing clients onto a single VGA memory write port.
//   Client 0 (screen clear) has absolute priority when the port is idle.
//   Clients 1-3 (sprite/brick drawers) are served round-robin. An owner keeps
//   the port until it drops its request; clients 1-3 are force-released with
//   an abort pulse after MAX_BURST owned cycles. Every release is followed by
//   one idle GAP cycle before the next arbitration.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset
//   req[3:0]     : per-client request
//   pix_x_in     : client i x at [10i+9:10i]
//   pix_y_in     : client i y at [9i+8:9i]
//   pix_color_in : client i RGB333 colour at [9i+8:9i]
//   pix_we_in    : per-client pixel write strobe
//   grant        : registered one-hot ownership
//   abort        : one-cycle pulse to a client whose burst was cut short
//   vga_x/y/color: registered pixel to VGA memory
//   vga_write    : registered memory write enable
//   busy         : high whenever the arbiter is not IDLE
module vga_write_arbiter #(
  parameter int unsigned MAX_BURST = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [39:0] pix_x_in,
  input  logic [35:0] pix_y_in,
  input  logic [35:0] pix_color_in,
  input  logic [3:0]  pix_we_in,
  output logic [3:0]  grant,
  output logic [3:0]  abort,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic [8:0]  vga_color,
  output logic        vga_write,
  output logic        busy
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

  state_t          state;
  logic [1:0]      owner;
  logic [1:0]      rr;
  logic [CW-1:0]   burst_cnt;

  logic [1:0]      winner;
  logic [1:0]      c1, c2, c3;
  logic [9:0]      sel_x;
  logic [8:0]      sel_y;
  logic [8:0]      sel_color;
  logic            in_range;
  logic            timeout;

  assign busy = (state != IDLE);

  // Round-robin candidate order over {1,2,3}, starting after the last served.
  always_comb begin
    c1 = (rr == 2'd3) ? 2'd1 : rr + 2'd1;
    c2 = (c1 == 2'd3) ? 2'd1 : c1 + 2'd1;
    c3 = (c2 == 2'd3) ? 2'd1 : c2 + 2'd1;
    winner = 2'd0;
    if (req[0])       winner = 2'd0;
    else if (req[c1]) winner = c1;
    else if (req[c2]) winner = c2;
    else if (req[c3]) winner = c3;
  end

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    case (owner)
      2'd0: begin
        sel_x = pix_x_in[9:0];   sel_y = pix_y_in[8:0];   sel_color = pix_color_in[8:0];
      end
      2'd1: begin
        sel_x = pix_x_in[19:10]; sel_y = pix_y_in[17:9];  sel_color = pix_color_in[17:9];
      end
      2'd2: begin
        sel_x = pix_x_in[29:20]; sel_y = pix_y_in[26:18]; sel_color = pix_color_in[26:18];
      end
      default: begin
        sel_x = pix_x_in[39:30]; sel_y = pix_y_in[35:27]; sel_color = pix_color_in[35:27];
      end
    endcase
  end

  assign in_range = (sel_x <= 10'd639) && (sel_y <= 9'd479);
  // Client 0 never times out; its counter is allowed to wrap harmlessly.
  assign timeout  = (owner != 2'd0) && (burst_cnt == CW'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      abort     <= '0;
      vga_write <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      owner     <= '0;
      rr        <= 2'd3;
      burst_cnt <= '0;
    end else begin
      abort <= '0;
      case (state)
        IDLE: begin
          grant     <= '0;
          vga_write <= 1'b0;
          if (|req) begin
            owner     <= winner;
            grant     <= 4'b0001 << winner;
            burst_cnt <= '0;
            state     <= OWNED;
            if (winner != 2'd0) rr <= winner;
          end
        end
        OWNED: begin
          vga_x     <= sel_x;
          vga_y     <= sel_y;
          vga_color <= sel_color;
          burst_cnt <= burst_cnt + 1'b1;
          // A request drop wins over a coincident timeout: plain release.
          if (!req[owner]) begin
            grant     <= '0;
            vga_write <= 1'b0;
            state     <= GAP;
          end else if (timeout) begin
            grant        <= '0;
            abort[owner] <= 1'b1;
            vga_write    <= 1'b0;
            state        <= GAP;
          end else begin
            vga_write <= pix_we_in[owner] & in_range;
          end
        end
        GAP: begin
          grant     <= '0;
          vga_write <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          grant     <= '0;
          vga_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] pix_x_in;
  logic [35:0] pix_y_in;
  logic [35:0] pix_color_in;
  logic [3:0]  pix_we_in;
  logic [3:0]  grant;
  logic [3:0]  abort;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [8:0]  vga_color;
  logic        vga_write;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  vga_write_arbiter #(.MAX_BURST(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .pix_x_in     (pix_x_in),
    .pix_y_in     (pix_y_in),
    .pix_color_in (pix_color_in),
    .pix_we_in    (pix_we_in),
    .grant        (grant),
    .abort        (abort),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_color    (vga_color),
    .vga_write    (vga_write),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [9:0] x, input logic [8:0] y,
                         input logic [8:0] c, input logic we);
    pix_x_in[10*i +: 10]   = x;
    pix_y_in[9*i +: 9]     = y;
    pix_color_in[9*i +: 9] = c;
    pix_we_in[i]           = we;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0;
    pix_x_in = '0; pix_y_in = '0; pix_color_in = '0; pix_we_in = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({grant, abort, vga_write, busy, vga_x, vga_y, vga_color} !== '0) begin
      failures++;
      $display("FAIL reset_state: grant=%b abort=%b wr=%b busy=%b x=%0d y=%0d c=%h expected all zero",
               grant, abort, vga_write, busy, vga_x, vga_y, vga_color);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [3] = '{4'b0100, 4'b1000, 4'b0010};
    req = 4'b1110;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      failures++; $display("FAIL rr_first: grant=%b expected 0010", grant);
    end
    for (int i = 0; i < 3; i++) begin
      req = '0;
      tick();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b1) begin
        failures++; $display("FAIL rr_gap%0d: grant=%b busy=%b expected 0000/1", i, grant, busy);
      end
      req = 4'b1110;
      tick();
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0000) begin
        failures++; $display("FAIL rr_idle%0d: grant=%b busy=%b expected 0000/0", i, grant, busy);
      end
      tick();
      checks++;
      if (grant !== exp_seq[i]) begin
        failures++; $display("FAIL rr_next%0d: grant=%b expected %b", i, grant, exp_seq[i]);
      end
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_data_path();
    set_pix(2, 10'd100, 9'd50, 9'h1FF, 1'b1);
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || vga_write !== 1'b0) begin
      failures++; $display("FAIL data_grant: grant=%b wr=%b expected 0100/0", grant, vga_write);
    end
    tick();
    checks++;
    if (vga_x !== 10'd100 || vga_y !== 9'd50 || vga_color !== 9'h1FF || vga_write !== 1'b1) begin
      failures++;
      $display("FAIL data_pixel: x=%0d y=%0d c=%h wr=%b expected 100/50/1ff/1", vga_x, vga_y, vga_color, vga_write);
    end
    set_pix(2, 10'd200, 9'd480, 9'h0A5, 1'b1);
    tick();
    checks++;
    if (vga_x !== 10'd200 || vga_y !== 9'd480 || vga_color !== 9'h0A5 || vga_write !== 1'b0) begin
      failures++;
      $display("FAIL data_y_range: x=%0d y=%0d c=%h wr=%b expected 200/480/0a5/0", vga_x, vga_y, vga_color, vga_write);
    end
    set_pix(2, 10'd300, 9'd20, 9'h055, 1'b0);
    tick();
    checks++;
    if (vga_x !== 10'd300 || vga_write !== 1'b0) begin
      failures++; $display("FAIL data_we_low: x=%0d wr=%b expected 300/0", vga_x, vga_write);
    end
    req = '0;
    tick();
    tick();
    checks++;
    if (vga_x !== 10'd300 || vga_y !== 9'd20 || vga_color !== 9'h055 || grant !== 4'b0000 || vga_write !== 1'b0) begin
      failures++;
      $display("FAIL data_hold: x=%0d y=%0d c=%h grant=%b wr=%b expected 300/20/055/0000/0",
               vga_x, vga_y, vga_color, grant, vga_write);
    end
    pix_we_in = '0;
  endtask

  task automatic test_out_of_range();
    set_pix(1, 10'd640, 9'd10, 9'h111, 1'b1);
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (vga_write !== 1'b0 || vga_x !== 10'd640 || grant !== 4'b0010) begin
      failures++; $display("FAIL oor_x640: wr=%b x=%0d grant=%b expected 0/640/0010", vga_write, vga_x, grant);
    end
    set_pix(1, 10'd639, 9'd479, 9'h122, 1'b1);
    tick();
    checks++;
    if (vga_write !== 1'b1 || vga_x !== 10'd639 || vga_y !== 9'd479) begin
      failures++; $display("FAIL oor_edge: wr=%b x=%0d y=%0d expected 1/639/479", vga_write, vga_x, vga_y);
    end
    req = '0; pix_we_in = '0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    set_pix(3, 10'd5, 9'd5, 9'h007, 1'b1);
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      failures++; $display("FAIL to_grant: grant=%b expected 1000", grant);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== 4'b1000 || abort !== 4'b0000 || vga_write !== 1'b1) begin
        failures++;
        $display("FAIL to_hold%0d: grant=%b abort=%b wr=%b expected 1000/0000/1", i, grant, abort, vga_write);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || abort !== 4'b1000 || vga_write !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL to_abort: grant=%b abort=%b wr=%b busy=%b expected 0000/1000/0/1", grant, abort, vga_write, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || abort !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL to_gap_end: grant=%b abort=%b busy=%b expected 0000/0000/0", grant, abort, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      failures++; $display("FAIL to_rearb: grant=%b expected 1000", grant);
    end
    // Re-granted burst: drop request exactly on the timeout cycle.
    for (int i = 1; i < 8; i++) tick();
    req = '0;
    tick();
    checks++;
    if (grant !== 4'b0000 || abort !== 4'b0000) begin
      failures++; $display("FAIL to_simul_drop: grant=%b abort=%b expected 0000/0000", grant, abort);
    end
    tick();
    pix_we_in = '0;
  endtask

  task automatic test_client0_and_reset();
    req = 4'b0010;
    tick();
    req = 4'b0011;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (grant !== 4'b0010) begin
      failures++; $display("FAIL no_preempt: grant=%b expected 0010", grant);
    end
    req = 4'b0001;
    tick(); tick(); tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL c0_grant: grant=%b expected 0001", grant);
    end
    req = 4'b0011;
    set_pix(0, 10'd5, 9'd7, 9'h003, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || abort !== 4'b0000) begin
        failures++; $display("FAIL c0_long%0d: grant=%b abort=%b expected 0001/0000", i, grant, abort);
      end
    end
    checks++;
    if (vga_x !== 10'd5 || vga_y !== 9'd7 || vga_color !== 9'h003 || vga_write !== 1'b1) begin
      failures++;
      $display("FAIL c0_pixel: x=%0d y=%0d c=%h wr=%b expected 5/7/003/1", vga_x, vga_y, vga_color, vga_write);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = '0;
    checks++;
    if ({grant, abort, vga_write, busy, vga_x, vga_y, vga_color} !== '0) begin
      failures++;
      $display("FAIL reset_mid_burst: grant=%b abort=%b wr=%b busy=%b x=%0d y=%0d c=%h expected all zero",
               grant, abort, vga_write, busy, vga_x, vga_y, vga_color);
    end
    req = 4'b1110;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      failures++; $display("FAIL reset_rr: grant=%b expected 0010", grant);
    end
    req = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_data_path();
    test_out_of_range();
    test_timeout();
    test_client0_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
